// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file controller.
// Holds the datapath widths, the register count and the controller state enum.
package regfile_pkg;

  localparam int REG_W  = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;

  // INIT  : clear sweep writing zero into R0..R7
  // IDLE  : CPU owns the register file, debug requests accepted here
  // DWR   : debug write waiting for a free writeback slot
  // DRD   : debug address steered onto SR1
  // DCAP  : register-file SR1 data captured into dbg_rdata
  // DACK  : one-cycle completion pulse
  typedef enum logic [2:0] {
    INIT = 3'd0,
    IDLE = 3'd1,
    DWR  = 3'd2,
    DRD  = 3'd3,
    DCAP = 3'd4,
    DACK = 3'd5
  } state_t;

endpackage

// File: rtl/regfile_ctrl.sv
// Register-file controller arbitrating between CPU writeback and a debug port.
//
// After reset the controller sweeps R0..R7 to zero (8 cycles), then passes the
// CPU writeback/source selects through to the register file. Debug reads steal
// the SR1 read port for two stalled cycles; debug writes wait for a cycle in
// which the CPU is not writing back.
//
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   cpu_ld/cpu_dr/cpu_data     CPU writeback request, destination, data
//   cpu_sr1/cpu_sr2            CPU source-register selects
//   dbg_req/dbg_we/dbg_addr/dbg_wdata   debug request channel
//   dbg_ack/dbg_rdata          debug completion pulse and read result
//   rf_ld/rf_dr/rf_bus/rf_sr1/rf_sr2    register-file controls
//   rf_sr1_out                 register-file SR1 data (synchronous read)
//   cpu_stall                  CPU must not use SR1 data or issue work
//   init_done                  clear sweep finished
//   dbg_state                  current controller state, for observation
//
// Debug handshake: the requester raises dbg_req with dbg_we/dbg_addr/dbg_wdata
// stable and holds it until dbg_ack; dbg_ack is high for exactly one cycle and
// the requester drops dbg_req at the edge that closes that cycle. A request
// still high in IDLE is taken as a new transaction. Address and write data are
// latched at acceptance, so they may change afterwards.
module regfile_ctrl
  import regfile_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_ld,
  input  logic [ADDR_W-1:0] cpu_dr,
  input  logic [REG_W-1:0]  cpu_data,
  input  logic [ADDR_W-1:0] cpu_sr1,
  input  logic [ADDR_W-1:0] cpu_sr2,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [REG_W-1:0]  dbg_wdata,
  output logic              dbg_ack,
  output logic [REG_W-1:0]  dbg_rdata,
  output logic              rf_ld,
  output logic [ADDR_W-1:0] rf_dr,
  output logic [REG_W-1:0]  rf_bus,
  output logic [ADDR_W-1:0] rf_sr1,
  output logic [ADDR_W-1:0] rf_sr2,
  input  logic [REG_W-1:0]  rf_sr1_out,
  output logic              cpu_stall,
  output logic              init_done,
  output logic [2:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREG - 1);

  state_t              state_q,   state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [REG_W-1:0]    wdata_q,   wdata_d;
  logic [REG_W-1:0]    rdata_q,   rdata_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;

    rf_ld     = cpu_ld;
    rf_dr     = cpu_dr;
    rf_bus    = cpu_data;
    rf_sr1    = cpu_sr1;
    rf_sr2    = cpu_sr2;
    cpu_stall = 1'b0;
    init_done = 1'b1;
    dbg_ack   = 1'b0;

    case (state_q)
      INIT: begin
        rf_ld     = 1'b1;
        rf_dr     = clr_cnt_q;
        rf_bus    = '0;
        cpu_stall = 1'b1;
        init_done = 1'b0;
        clr_cnt_d = clr_cnt_q + 3'd1;
        if (clr_cnt_q == LAST_REG) state_d = IDLE;
      end
      IDLE: begin
        if (dbg_req) begin
          addr_d  = dbg_addr;
          wdata_d = dbg_wdata;
          state_d = dbg_we ? DWR : DRD;
        end
      end
      DWR: begin
        // CPU writeback has priority; the debug write takes the first free slot.
        if (!cpu_ld) begin
          rf_ld   = 1'b1;
          rf_dr   = addr_q;
          rf_bus  = wdata_q;
          state_d = DACK;
        end
      end
      DRD: begin
        // The register file reads synchronously: the address presented here is
        // sampled at this cycle's closing edge, ahead of any same-cycle write,
        // so a colliding CPU writeback does not affect the captured value.
        rf_sr1    = addr_q;
        cpu_stall = 1'b1;
        state_d   = DCAP;
      end
      DCAP: begin
        cpu_stall = 1'b1;
        rdata_d   = rf_sr1_out;
        state_d   = DACK;
      end
      DACK: begin
        dbg_ack = 1'b1;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  assign dbg_rdata = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have ports: Clk  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL have ports: Reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: cpu_ld  in  1  CPU writeback request; cpu_dr  in  3  CPU destination register; cpu_data  in  16  CPU writeback data.
REQ-004 SHALL have ports: cpu_sr1, cpu_sr2  in  3 each  CPU source-register selects.
REQ-005 SHALL have ports: dbg_req  in  1  debug request, held until ack; dbg_we  in  1  1=write, 0=read; dbg_addr  in  3  debug register index; dbg_wdata  in  16  debug write data.
REQ-006 SHALL have ports: dbg_ack  out  1  one-cycle completion pulse; dbg_rdata  out  16  debug read result.
REQ-007 SHALL have ports: rf_ld  out  1; rf_dr  out  3; rf_bus  out  16; rf_sr1, rf_sr2  out  3 each  register-file controls; rf_sr1_out  in  16  register-file SR1 data.
REQ-008 SHALL have ports: cpu_stall  out  1  CPU must not use SR1 data or issue work this cycle; init_done  out  1  clear sweep finished.

Function
REQ-009 SHALL implement FSM states INIT, IDLE, DWR, DRD, DCAP, DACK, plus a 3-bit clear counter clr_cnt.
REQ-010 INIT SHALL drive rf_ld=1, rf_dr=clr_cnt, rf_bus=0, cpu_stall=1, and increment clr_cnt each cycle; clr_cnt==7 -> IDLE (8 cycles, R0..R7 zeroed).
REQ-011 init_done SHALL be 0 in INIT and 1 in all other states.
REQ-012 Outside INIT, rf_ld/rf_dr/rf_bus SHALL pass cpu_ld/cpu_dr/cpu_data through, except in DWR with cpu_ld=0.
REQ-013 rf_sr2 SHALL always equal cpu_sr2; rf_sr1 SHALL equal cpu_sr1 except in DRD, where it equals the latched debug address.
REQ-014 IDLE: dbg_req=1 SHALL latch dbg_addr and dbg_wdata and go to DWR if dbg_we=1, else DRD; dbg_req=0 stays in IDLE.
REQ-015 DWR: cpu_ld=1 SHALL hold in DWR (CPU priority, no timeout); cpu_ld=0 SHALL drive rf_ld=1, rf_dr=latched addr, rf_bus=latched data, then go to DACK.
REQ-016 DRD SHALL go to DCAP after one cycle; DCAP SHALL load dbg_rdata <= rf_sr1_out at its closing edge, then go to DACK.
REQ-017 cpu_stall SHALL be 1 in INIT, DRD and DCAP, and 0 otherwise.
REQ-018 DACK SHALL assert dbg_ack=1 for exactly one cycle, then return to IDLE; dbg_rdata SHALL hold until the next debug read completes.
REQ-019 A debug read issued while the CPU writes the same register in DRD SHALL return the pre-write value.
REQ-020 A requester SHALL drop dbg_req at the edge closing DACK; a request still high in IDLE is a new transaction.
REQ-021 Debug read latency SHALL be 4 cycles, from the IDLE acceptance edge to the dbg_ack cycle; debug write latency SHALL be 3 cycles plus any cycles cpu_ld holds DWR.

Reset
REQ-022 A clock edge with Reset=1 SHALL force state=INIT, clr_cnt=0 and dbg_rdata=0, from any state.
REQ-023 A pending debug transaction SHALL be dropped without ack when reset occurs mid-operation.
REQ-024 Values after reset SHALL be dbg_ack=0, init_done=0, cpu_stall=1, rf_ld=1, rf_dr=0, rf_bus=0.

Structure
REQ-025 Package regfile_pkg SHALL hold the state enum and constants REG_W=16, ADDR_W=3, NREG=8.
REQ-026 SHALL be a single module with no sub-modules; state and registers in one always_ff, decode in always_comb.

Verification
REQ-027 Reset 1 cycle, release -> rf_ld=1 with rf_dr=0..7 and rf_bus=0 for 8 cycles, then init_done=1 and cpu_stall=0.
REQ-028 After init, debug write addr=3 data=16'hBEEF with cpu_ld=0 -> one rf_ld pulse with dr=3, bus=BEEF; dbg_ack 3 cycles after acceptance.
REQ-029 Debug write addr=5 while cpu_ld=1 for 4 cycles -> CPU writes pass through; debug write occurs in the first cpu_ld=0 cycle, then ack.
REQ-030 Preload R6=16'h1234, debug read addr=6 -> cpu_stall high 2 cycles; dbg_rdata=1234 with dbg_ack 4 cycles after acceptance.
REQ-031 Debug read R2 (old 16'h0001) while CPU writes R2=16'h00FF in the DRD cycle -> dbg_rdata=0001; a later read returns 00FF.
REQ-032 Reset asserted in DCAP -> no ack, dbg_rdata=0, clear sweep restarts at clr_cnt=0.
